normalize_stream: RTL and testbench

Pipelined mantissa normalizer that sits directly downstream of the leading-zero counter in the floating-point datapath. It accepts a raw mantissa/exponent pair over a valid/ready stream, counts leading zeros from the MSB, and left-shifts the mantissa until its MSB is set. It decrements the exponent by the shift amount and clamps at exponent zero, producing a denormal result. Output is a valid/ready stream with a fixed two-cycle latency and full throughput.

---
 rtl/normalize_stream_if.sv | 29 ++
 rtl/normalize_stream.sv | 115 +++++++++++
 tb/tb_normalize_stream.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/normalize_stream_if.sv
// rtl/normalize_stream_if.sv - Input/output stream bundle for the mantissa normalizer.
interface normalize_stream_if #(
   parameter int WIDTH     = 32,
   parameter int EXP_WIDTH = 8
);
   localparam int SW = $clog2(WIDTH);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_mantissa;
   logic [EXP_WIDTH-1:0] in_exponent;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_mantissa;
   logic [EXP_WIDTH-1:0] out_exponent;
   logic [SW-1:0]        out_shift;
   logic                 out_zero;
   logic                 out_underflow;

   modport master (
      output in_valid, in_mantissa, in_exponent, out_ready,
      input  in_ready, out_valid, out_mantissa, out_exponent, out_shift, out_zero, out_underflow
   );

   modport slave (
      input  in_valid, in_mantissa, in_exponent, out_ready,
      output in_ready, out_valid, out_mantissa, out_exponent, out_shift, out_zero, out_underflow
   );
endinterface

// File: rtl/normalize_stream.sv
// rtl/normalize_stream.sv - Two-stage mantissa normalizer with exponent clamp to denormal.
// Stage 1 captures the leading-zero count, stage 2 applies the shift and drives the outputs.
module normalize_stream #(
   parameter int WIDTH     = 32,
   parameter int EXP_WIDTH = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   normalize_stream_if.slave   bus
);
   localparam int SW = $clog2(WIDTH);
   localparam int CW = (SW > EXP_WIDTH) ? SW : EXP_WIDTH;

   logic                 r_s1_valid;
   logic [WIDTH-1:0]     r_s1_mant;
   logic [EXP_WIDTH-1:0] r_s1_exp;
   logic [SW-1:0]        r_s1_lz;
   logic                 r_s1_zero;

   logic                 r_out_valid;
   logic [WIDTH-1:0]     r_out_mant;
   logic [EXP_WIDTH-1:0] r_out_exp;
   logic [SW-1:0]        r_out_shift;
   logic                 r_out_zero;
   logic                 r_out_uf;

   logic                 w_s2_adv;
   logic                 w_s1_adv;
   logic [SW-1:0]        w_lz;
   logic                 w_zero;
   logic                 w_uf;
   logic [SW-1:0]        w_shift;
   logic [EXP_WIDTH-1:0] w_exp;
   logic [WIDTH-1:0]     w_mant;

   assign w_s2_adv = !r_out_valid || bus.out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;

   // Highest set bit wins; the all-zero case is flagged separately and lz is ignored.
   always_comb begin
      w_lz = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bus.in_mantissa[i]) begin
            w_lz = SW'(WIDTH - 1 - i);
         end
      end
   end

   assign w_zero = (bus.in_mantissa == '0);

   always_comb begin
      w_uf    = 1'b0;
      w_shift = '0;
      w_exp   = '0;
      w_mant  = '0;
      if (!r_s1_zero) begin
         if (CW'(r_s1_lz) > CW'(r_s1_exp)) begin
            // Exponent runs out first: shift only by what it can absorb.
            w_uf    = 1'b1;
            w_shift = SW'(r_s1_exp);
            w_exp   = '0;
         end else begin
            w_shift = r_s1_lz;
            w_exp   = r_s1_exp - EXP_WIDTH'(r_s1_lz);
         end
         w_mant = r_s1_mant << w_shift;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1_valid <= 1'b0;
         r_s1_mant  <= '0;
         r_s1_exp   <= '0;
         r_s1_lz    <= '0;
         r_s1_zero  <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1_mant <= bus.in_mantissa;
            r_s1_exp  <= bus.in_exponent;
            r_s1_lz   <= w_lz;
            r_s1_zero <= w_zero;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_out_valid <= 1'b0;
         r_out_mant  <= '0;
         r_out_exp   <= '0;
         r_out_shift <= '0;
         r_out_zero  <= 1'b0;
         r_out_uf    <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_mant  <= w_mant;
            r_out_exp   <= w_exp;
            r_out_shift <= w_shift;
            r_out_zero  <= r_s1_zero;
            r_out_uf    <= w_uf;
         end
      end
   end

   assign bus.in_ready      = w_s1_adv;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_mantissa  = r_out_mant;
   assign bus.out_exponent  = r_out_exp;
   assign bus.out_shift     = r_out_shift;
   assign bus.out_zero      = r_out_zero;
   assign bus.out_underflow = r_out_uf;
endmodule

// File: tb/tb_normalize_stream.sv
// tb/tb_normalize_stream.sv - Directed and randomized checks of normalize_stream at WIDTH=8, EXP_WIDTH=4.
module tb_normalize_stream;
   localparam int W  = 8;
   localparam int EW = 4;

   logic i_clk   = 1'b0;
   logic i_reset = 1'b1;
   always #5 i_clk = ~i_clk;

   normalize_stream_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

   normalize_stream #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   typedef struct packed {
      logic [7:0] m;
      logic [3:0] e;
      logic [2:0] s;
      logic       z;
      logic       u;
      int         cyc;
   } beat_t;

   beat_t      q[$];
   beat_t      held;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   int         n_out = 0;
   int         b;
   int         k;
   int         out_base;
   bit         lat_chk = 0;
   bit         hold    = 0;
   logic       acc;
   logic [7:0] rm;
   logic [3:0] re;
   logic [7:0] bp_m [6];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: shift one bit at a time while the exponent can pay for it.
   function automatic beat_t model(input logic [7:0] m, input logic [3:0] e);
      beat_t      r;
      logic [7:0] mm;
      logic [3:0] ee;
      logic [2:0] sh;
      r  = '0;
      mm = m;
      ee = e;
      sh = '0;
      if (m == 8'h00) begin
         r.z = 1'b1;
      end else begin
         while (!mm[7] && ee != 4'd0) begin
            mm = mm << 1;
            ee = ee - 4'd1;
            sh = sh + 3'd1;
         end
         r.m = mm;
         r.e = ee;
         r.s = sh;
         r.u = !mm[7];
      end
      return r;
   endfunction

   task automatic cycle(input logic v, input logic [7:0] m, input logic [3:0] e,
                        input logic rdy, output logic a);
      beat_t x;
      bus.in_valid    = v;
      bus.in_mantissa = m;
      bus.in_exponent = e;
      bus.out_ready   = rdy;
      #1;
      if (hold) begin
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_mant", bus.out_mantissa, held.m);
         chk("hold_exp", bus.out_exponent, held.e);
         chk("hold_shift", bus.out_shift, held.s);
         chk("hold_zero", bus.out_zero, held.z);
         chk("hold_uf", bus.out_underflow, held.u);
      end
      hold   = bus.out_valid && !rdy;
      held.m = bus.out_mantissa;
      held.e = bus.out_exponent;
      held.s = bus.out_shift;
      held.z = bus.out_zero;
      held.u = bus.out_underflow;
      a = v && bus.in_ready;
      if (bus.out_valid && rdy) begin
         if (q.size() == 0) begin
            chk("spurious_out", bus.out_valid, 0);
         end else begin
            x = q.pop_front();
            chk("sb_mant", bus.out_mantissa, x.m);
            chk("sb_exp", bus.out_exponent, x.e);
            chk("sb_shift", bus.out_shift, x.s);
            chk("sb_zero", bus.out_zero, x.z);
            chk("sb_uf", bus.out_underflow, x.u);
            if (lat_chk) chk("latency", cyc - x.cyc, 2);
            n_out++;
         end
      end
      if (a) begin
         x = model(m, e);
         x.cyc = cyc;
         q.push_back(x);
      end
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic send(input string tag, input logic [7:0] m, input logic [3:0] e,
                       input logic [7:0] xm, input logic [3:0] xe, input logic [2:0] xs,
                       input logic xz, input logic xu);
      bus.in_valid    = 1'b1;
      bus.in_mantissa = m;
      bus.in_exponent = e;
      bus.out_ready   = 1'b1;
      #1;
      chk({tag, "_in_ready"}, bus.in_ready, 1);
      @(posedge i_clk);
      #1;
      bus.in_valid = 1'b0;
      chk({tag, "_valid_n1"}, bus.out_valid, 0);
      @(posedge i_clk);
      #1;
      chk({tag, "_valid_n2"}, bus.out_valid, 1);
      chk({tag, "_mant"}, bus.out_mantissa, xm);
      chk({tag, "_exp"}, bus.out_exponent, xe);
      chk({tag, "_shift"}, bus.out_shift, xs);
      chk({tag, "_zero"}, bus.out_zero, xz);
      chk({tag, "_uf"}, bus.out_underflow, xu);
      @(posedge i_clk);
      #1;
      chk({tag, "_consumed"}, bus.out_valid, 0);
   endtask

   initial begin
      bus.in_valid    = 1'b0;
      bus.in_mantissa = '0;
      bus.in_exponent = '0;
      bus.out_ready   = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_mant", bus.out_mantissa, 0);
      chk("rst_exp", bus.out_exponent, 0);
      chk("rst_shift", bus.out_shift, 0);
      chk("rst_zero", bus.out_zero, 0);
      chk("rst_uf", bus.out_underflow, 0);
      chk("rst_in_ready", bus.in_ready, 1);

      send("basic", 8'h10, 4'd10, 8'h80, 4'd7, 3'd3, 1'b0, 1'b0);
      send("msb_e0", 8'h80, 4'd0, 8'h80, 4'd0, 3'd0, 1'b0, 1'b0);
      send("lz_eq_exp", 8'h20, 4'd2, 8'h80, 4'd0, 3'd2, 1'b0, 1'b0);
      send("underflow", 8'h01, 4'd3, 8'h08, 4'd0, 3'd3, 1'b0, 1'b1);
      send("zero", 8'h00, 4'd5, 8'h00, 4'd0, 3'd0, 1'b1, 1'b0);

      // Backpressure: six beats offered with the consumer stalled.
      bp_m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      b = 0;
      out_base = n_out;
      for (int c = 0; c < 6; c++) begin
         cycle(b < 6, bp_m[(b < 6) ? b : 0], 4'd15, 1'b0, acc);
         if (acc) b++;
      end
      chk("bp_accepted", b, 2);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_head_valid", bus.out_valid, 1);
      chk("bp_head_mant", bus.out_mantissa, 8'h80);
      chk("bp_head_exp", bus.out_exponent, 4'd8);
      for (int c = 0; c < 30 && (n_out - out_base) < 6; c++) begin
         cycle(b < 6, bp_m[(b < 6) ? b : 0], 4'd15, 1'b1, acc);
         if (acc) b++;
      end
      chk("bp_out_count", n_out - out_base, 6);
      chk("bp_queue_empty", q.size(), 0);

      // Full rate: one accept every cycle, fixed latency of two.
      lat_chk = 1;
      b = 0;
      k = 0;
      out_base = n_out;
      while (k < 300 && b < 100) begin
         rm = 8'($urandom_range(0, 255) >> $urandom_range(0, 8));
         re = 4'($urandom_range(0, 15));
         cycle(1'b1, rm, re, 1'b1, acc);
         if (acc) b++;
         k++;
      end
      chk("fr_accepted", b, 100);
      chk("fr_cycles", k, 100);
      for (int c = 0; c < 5; c++) cycle(1'b0, 8'h00, 4'd0, 1'b1, acc);
      chk("fr_out_count", n_out - out_base, 100);
      chk("fr_queue_empty", q.size(), 0);
      lat_chk = 0;

      // Random valid/ready toggling.
      b = 0;
      k = 0;
      out_base = n_out;
      while (k < 10000 && b < 1000) begin
         rm = 8'($urandom_range(0, 255) >> $urandom_range(0, 8));
         re = 4'($urandom_range(0, 15));
         cycle(1'($urandom_range(0, 1)), rm, re, 1'($urandom_range(0, 1)), acc);
         if (acc) b++;
         k++;
      end
      for (int c = 0; c < 20 && q.size() != 0; c++) cycle(1'b0, 8'h00, 4'd0, 1'b1, acc);
      chk("rnd_accepted", b, 1000);
      chk("rnd_out_count", n_out - out_base, 1000);
      chk("rnd_queue_empty", q.size(), 0);

      // Reset with both stages full; the two beats must vanish.
      cycle(1'b1, 8'h11, 4'd9, 1'b0, acc);
      cycle(1'b1, 8'h22, 4'd9, 1'b0, acc);
      chk("mid_full_in_ready", bus.in_ready, 0);
      bus.in_valid    = 1'b1;
      bus.in_mantissa = 8'h33;
      bus.out_ready   = 1'b1;
      i_reset         = 1'b1;
      @(posedge i_clk);
      #1;
      i_reset      = 1'b0;
      bus.in_valid = 1'b0;
      q.delete();
      hold = 0;
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_mant", bus.out_mantissa, 0);
      chk("mid_rst_exp", bus.out_exponent, 0);
      chk("mid_rst_shift", bus.out_shift, 0);
      chk("mid_rst_zero", bus.out_zero, 0);
      chk("mid_rst_uf", bus.out_underflow, 0);
      chk("mid_rst_in_ready", bus.in_ready, 1);
      out_base = n_out;
      for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 4'd0, 1'b1, acc);
      cycle(1'b1, 8'h40, 4'd1, 1'b1, acc);
      for (int c = 0; c < 4; c++) cycle(1'b0, 8'h00, 4'd0, 1'b1, acc);
      chk("post_rst_out_count", n_out - out_base, 1);
      chk("post_rst_queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
